// File: rtl/cats_led_arbiter.sv
// Round-robin arbiter sharing the 8 "cats" LEDs between NUM_SRC pattern sources,
// with a blank gap between owners and player lock/skip controls.
module cats_led_arbiter #(
    parameter int CLK_FREQ    = 48_000_000,
    parameter int NUM_SRC     = 4,
    parameter int SLICE_TICKS = CLK_FREQ / 2,
    parameter int GAP_TICKS   = CLK_FREQ / 50
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [8*NUM_SRC-1:0]       pattern_in,
    input  logic                       lock,
    input  logic                       btn_next,
    output logic [7:0]                 cats,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] owner,
    output logic                       owner_valid
);

    localparam int OW       = $clog2(NUM_SRC);
    localparam int MAX_TICK = (SLICE_TICKS > GAP_TICKS) ? SLICE_TICKS : GAP_TICKS;
    localparam int CW       = $clog2(MAX_TICK + 1);

    typedef enum logic [1:0] {IDLE, SCAN, SHOW, GAP} state_t;

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       slice_cnt;
    logic [CW-1:0]       gap_cnt;
    logic                slice_end;
    logic                gap_end;
    logic                others_req;
    logic                scan_found;
    logic [OW-1:0]       scan_idx;
    logic [OW-1:0]       cand_idx;
    int                  cand;
    logic [OW-1:0]       owner_next;
    logic [NUM_SRC-1:0]  owner_oh;
    logic [7:0]          cats_d;
    logic [NUM_SRC-1:0]  grant_d;
    logic                valid_d;

    assign slice_end  = (slice_cnt == CW'(SLICE_TICKS - 1));
    assign gap_end    = (gap_cnt == CW'(GAP_TICKS - 1));
    assign owner_oh   = NUM_SRC'(1) << owner;
    assign others_req = |(req & ~owner_oh);

    // Walk candidates from furthest to nearest so the nearest requester after the owner wins;
    // the current owner itself is considered last.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = owner;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = int'(owner) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = OW'(cand);
            if (req[cand_idx]) begin
                scan_found = 1'b1;
                scan_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (|req) next_state = SCAN;
            SCAN: next_state = scan_found ? SHOW : IDLE;
            SHOW: begin
                if (!req[owner] || btn_next || (slice_end && !lock && others_req)) begin
                    next_state = GAP;
                end
            end
            GAP:  if (gap_end) next_state = SCAN;
            default: next_state = IDLE;
        endcase
    end

    // Output values are computed for the state being entered, then registered,
    // so grant and cats appear on the same edge that enters SHOW.
    always_comb begin
        owner_next = (state == SCAN && scan_found) ? scan_idx : owner;
        valid_d    = (next_state == SHOW);
        cats_d     = 8'h00;
        grant_d    = '0;
        if (valid_d) begin
            grant_d = NUM_SRC'(1) << owner_next;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (owner_next == OW'(i)) begin
                    cats_d = pattern_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cats        <= 8'h00;
            grant       <= '0;
            owner_valid <= 1'b0;
            owner       <= OW'(NUM_SRC - 1);
            slice_cnt   <= '0;
            gap_cnt     <= '0;
        end else begin
            cats        <= cats_d;
            grant       <= grant_d;
            owner_valid <= valid_d;
            owner       <= owner_next;
            slice_cnt   <= (state == SHOW && next_state == SHOW && !slice_end) ?
                           slice_cnt + CW'(1) : '0;
            gap_cnt     <= (state == GAP && next_state == GAP) ? gap_cnt + CW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_cats_led_arbiter.sv
// Randomised plus directed bench for cats_led_arbiter: a slice/gap reference model
// queues the expected LED outputs per edge and a monitor compares them.
module tb_cats_led_arbiter;

    localparam int N  = 4;
    localparam int SL = 8;
    localparam int GP = 2;

    typedef struct packed {
        logic [7:0]   cats;
        logic [N-1:0] grant;
        logic [1:0]   owner;
        logic         valid;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [8*N-1:0] pattern_in;
    logic         lock;
    logic         btn_next;
    logic [7:0]   cats;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         owner_valid;

    resp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: who owns the LEDs, how long into the slice, blank cycles left.
    int m_owner = N - 1;
    bit m_show  = 1'b0;
    int m_age   = 0;
    int m_wait  = 0;

    always #5 clk = ~clk;

    cats_led_arbiter #(
        .CLK_FREQ    (48_000_000),
        .NUM_SRC     (N),
        .SLICE_TICKS (SL),
        .GAP_TICKS   (GP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .pattern_in  (pattern_in),
        .lock        (lock),
        .btn_next    (btn_next),
        .cats        (cats),
        .grant       (grant),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    function automatic logic [7:0] pattern_of(input int src);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (i == src) p = pattern_in[8*i +: 8];
        end
        return p;
    endfunction

    task automatic model_edge();
        resp_t r;
        bit    others;
        if (!rst_n) begin
            m_owner = N - 1;
            m_show  = 1'b0;
            m_age   = 0;
            m_wait  = 0;
        end else if (m_show) begin
            others = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i != m_owner && req[i]) others = 1'b1;
            end
            if (!req[m_owner] || btn_next || (m_age == SL - 1 && !lock && others)) begin
                m_show = 1'b0;
                m_wait = GP + 1;
            end else begin
                m_age = (m_age == SL - 1) ? 0 : m_age + 1;
            end
        end else if (m_wait > 1) begin
            m_wait--;
        end else if (m_wait == 1) begin
            m_wait = 0;
            for (int k = 1; k <= N; k++) begin
                if (req[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N;
                    m_show  = 1'b1;
                    m_age   = 0;
                    break;
                end
            end
        end else if (req != '0) begin
            m_wait = 1;
        end
        r.cats  = m_show ? pattern_of(m_owner) : 8'h00;
        r.grant = m_show ? N'(1) << m_owner : '0;
        r.owner = 2'(m_owner);
        r.valid = m_show;
        exp_q.push_back(r);
    endtask

    task automatic apply_stimulus(input logic rn, input logic [N-1:0] rq,
                                  input logic lk, input logic bt);
        rst_n    = rn;
        req      = rq;
        lock     = lk;
        btn_next = bt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_output(input resp_t e);
        resp_t got;
        got.cats  = cats;
        got.grant = grant;
        got.owner = owner;
        got.valid = owner_valid;
        tests++;
        if (got !== e) begin
            fails++;
            $display("[TB] FAIL outputs @%0t: got cats=%h grant=%b owner=%0d valid=%b, expected cats=%h grant=%b owner=%0d valid=%b",
                     $time, got.cats, got.grant, got.owner, got.valid,
                     e.cats, e.grant, e.owner, e.valid);
        end
    endtask

    task automatic report_timeout(input string what);
        tests++;
        fails++;
        $display("[TB] FAIL wait %s: condition not reached, required within 200 cycles", what);
    endtask

    always @(negedge clk) begin : monitor
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
        end
    end

    initial begin
        int n;
        pattern_in = {8'h88, 8'h44, 8'h22, 8'h11};
        rst_n = 1'b0; req = '0; lock = 1'b0; btn_next = 1'b0;

        // Reset held with all sources requesting, then a full round-robin rotation.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);

        // Lock owner 1, then skip with btn_next while still locked.
        n = 0;
        while (!(m_show && m_owner == 1) && n < 200) begin
            apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
            n++;
        end
        if (n >= 200) report_timeout("owner1");
        for (int i = 0; i < 30; i++) apply_stimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        apply_stimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 4'b1111, 1'b1, 1'b0);

        // Owner 2 drops its request at slice count 3, then again together with btn_next.
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            while (!(m_show && m_owner == 2 && m_age == 3) && n < 200) begin
                apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
                n++;
            end
            if (n >= 200) report_timeout("owner2");
            apply_stimulus(1'b1, 4'b1011, 1'b0, pass == 1);
            for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 4'b1011, 1'b0, 1'b0);
        end

        // Single requester keeps the LEDs across several slice boundaries.
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 4'b0100, 1'b0, 1'b0);

        // Reset while owner 3 is showing.
        n = 0;
        while (!(m_show && m_owner == 3) && n < 200) begin
            apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
            n++;
        end
        if (n >= 200) report_timeout("owner3");
        apply_stimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);

        // Live pattern change for source 0 while it owns the LEDs.
        pattern_in[7:0] = 8'h5A;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
        pattern_in[7:0] = 8'h11;

        // Randomised traffic with occasional lock, skip, pattern changes and reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) pattern_in = 32'($urandom);
            apply_stimulus(($urandom_range(0, 199) != 0),
                           4'($urandom_range(0, 15) | $urandom_range(0, 15)),
                           ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
